// File: rtl/pos_cache_cell_reader_pkg.sv
// Shared types and helpers for the cell position-cache reader.
// Holds the FSM encoding, position word width, count slice and cell tag order.
package pos_cache_cell_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ_NUM,
      ST_CAP_NUM,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // A position word is {posz, posy, posx}.
   localparam int unsigned COORDS = 3;

   // Address 0 holds the particle count in its low ADDR_WIDTH bits.
   localparam int unsigned COUNT_LSB = 0;

   function automatic int unsigned pos_width(input int unsigned dw);
      return COORDS * dw;
   endfunction

   // Cell tag is {x, y, z} with x in the most significant field.
   function automatic logic [63:0] cell_tag(
      input int unsigned x,
      input int unsigned y,
      input int unsigned z,
      input int unsigned w
   );
      logic [63:0] t;
      t = (64'(x) << (2 * w)) | (64'(y) << w) | 64'(z);
      return t;
   endfunction

endpackage

// File: rtl/pos_reader_fifo.sv
// Small synchronous FIFO carrying {last, id, pos} for the cell reader.
// Ports: push/din in, pop in, dout/valid registered head, occupancy count.
module pos_reader_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_n;
   logic [AW:0]      cnt_n;
   logic             wr_en;
   logic             rd_en;

   always_comb begin
      wr_en    = push;
      rd_en    = pop & valid;
      rd_ptr_n = rd_ptr + AW'(rd_en);
      cnt_n    = occupancy + (AW+1)'(wr_en) - (AW+1)'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   // The head register is reloaded every cycle from the slot that will
   // be at the head after this cycle's push/pop; when that slot is the
   // one being written right now the incoming word is taken directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         valid     <= 1'b0;
         dout      <= '0;
      end else begin
         wr_ptr    <= wr_ptr + AW'(wr_en);
         rd_ptr    <= rd_ptr_n;
         occupancy <= cnt_n;
         valid     <= (cnt_n != '0);
         if (cnt_n != '0) begin
            if (wr_en && (wr_ptr == rd_ptr_n)) begin
               dout <= din;
            end else begin
               dout <= mem[rd_ptr_n];
            end
         end
      end
   end

endmodule

// File: rtl/pos_cache_cell_reader.sv
// Reads a cell's position cache (count at addr 0, then 1..N) and streams
// each position to the force pipeline over valid/ready.
// Ports: start/motion_update_enable control; out_read_address/out_rden and
// in_particle_info to the cache; out_particle_pos/id/last/valid, in_ready
// to the consumer; busy, done, count_err status.
// Optional POS_READER_CELL_TAG_EN adds out_cell_id = {CELL_X,CELL_Y,CELL_Z}.
module pos_cache_cell_reader
   import pos_cache_cell_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int PARTICLE_NUM  = 220,
   parameter int ADDR_WIDTH    = 8,
   parameter int CELL_ID_WIDTH = 4,
   parameter int CELL_X        = 2,
   parameter int CELL_Y        = 2,
   parameter int CELL_Z        = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    motion_update_enable,
   output logic [ADDR_WIDTH-1:0]   out_read_address,
   output logic                    out_rden,
   input  logic [3*DATA_WIDTH-1:0] in_particle_info,
   output logic [3*DATA_WIDTH-1:0] out_particle_pos,
   output logic [ADDR_WIDTH-1:0]   out_particle_id,
   output logic                    out_valid,
   input  logic                    in_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done,
   output logic                    count_err
`ifdef POS_READER_CELL_TAG_EN
   ,
   output logic [3*CELL_ID_WIDTH-1:0] out_cell_id
`endif
);

   localparam int POS_W = int'(pos_width(DATA_WIDTH));
   localparam int FW    = 1 + ADDR_WIDTH + POS_W;
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT =
      ADDR_WIDTH'(PARTICLE_NUM - 1);
   localparam logic [63:0] TAG_FULL =
      cell_tag(CELL_X, CELL_Y, CELL_Z, CELL_ID_WIDTH);

   if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 4");
   end
   if ((TAG_FULL >> (3 * CELL_ID_WIDTH)) != 64'd0) begin : g_chk_cell
      $error("cell coordinate does not fit CELL_ID_WIDTH");
   end

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   count;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic [ADDR_WIDTH-1:0]   rd_addr_d1;
   logic                    rd_d1;
   logic [1:0]              in_flight;

   logic [ADDR_WIDTH-1:0]   raw_count;
   logic [ADDR_WIDTH-1:0]   cnt_clamped;
   logic                    cnt_over;
   logic [OCC_W:0]          pending;
   logic                    room;
   logic                    issue;
   logic                    push;
   logic                    push_last;
   logic                    pop;

   logic [FW-1:0]           fifo_din;
   logic [FW-1:0]           fifo_dout;
   logic [OCC_W-1:0]        fifo_occ;

   always_comb begin
      raw_count   = in_particle_info[COUNT_LSB +: ADDR_WIDTH];
      cnt_over    = raw_count > MAX_CNT;
      cnt_clamped = cnt_over ? MAX_CNT : raw_count;
      // Reads may only go out if every word already requested still
      // has a FIFO slot waiting for it.
      pending     = (OCC_W+1)'(fifo_occ) + (OCC_W+1)'(in_flight);
      room        = pending < (OCC_W+1)'(FIFO_DEPTH);
      issue       = (state == ST_STREAM) && room;
      // rd_d1 marks the cycle the cache drives data for a read; the
      // count read at address 0 is consumed by CAP_NUM, never pushed.
      push        = rd_d1 && ((state == ST_STREAM) || (state == ST_DRAIN));
      push_last   = (rd_addr_d1 == count);
      pop         = out_valid && in_ready;
      fifo_din    = {push_last, rd_addr_d1, in_particle_info};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         out_read_address <= '0;
         out_rden         <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         count_err        <= 1'b0;
         count            <= '0;
         next_addr        <= '0;
         rd_addr_d1       <= '0;
         rd_d1            <= 1'b0;
         in_flight        <= '0;
      end else begin
         rd_d1      <= out_rden;
         rd_addr_d1 <= out_read_address;
         out_rden   <= 1'b0;
         done       <= 1'b0;

         unique case ({issue, push})
            2'b10:   in_flight <= in_flight + 2'd1;
            2'b01:   in_flight <= in_flight - 2'd1;
            default: ;
         endcase

         unique case (state)
            ST_IDLE: begin
               if (start && !motion_update_enable) begin
                  out_read_address <= '0;
                  out_rden         <= 1'b1;
                  count_err        <= 1'b0;
                  busy             <= 1'b1;
                  state            <= ST_READ_NUM;
               end
            end
            ST_READ_NUM: begin
               state <= ST_CAP_NUM;
            end
            ST_CAP_NUM: begin
               count <= cnt_clamped;
               if (cnt_over) begin
                  count_err <= 1'b1;
               end
               if (cnt_clamped == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end else begin
                  next_addr <= ADDR_WIDTH'(1);
                  state     <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (issue) begin
                  out_rden         <= 1'b1;
                  out_read_address <= next_addr;
                  if (next_addr == count) begin
                     state <= ST_DRAIN;
                  end else begin
                     next_addr <= next_addr + ADDR_WIDTH'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (pop && out_last) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   pos_reader_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .din       (fifo_din),
      .pop       (pop),
      .dout      (fifo_dout),
      .valid     (out_valid),
      .occupancy (fifo_occ)
   );

   assign out_last         = fifo_dout[FW-1];
   assign out_particle_id  = fifo_dout[POS_W +: ADDR_WIDTH];
   assign out_particle_pos = fifo_dout[POS_W-1:0];

`ifdef POS_READER_CELL_TAG_EN
   localparam logic [3*CELL_ID_WIDTH-1:0] CELL_TAG =
      TAG_FULL[3*CELL_ID_WIDTH-1:0];

   assign out_cell_id = out_valid ? CELL_TAG : '0;
`endif

endmodule
